alu_sequencer: RTL

//  Control FSM that sequences the multi-stage ALU and the 4-entry register file over the shared N-bit bus.
//  - Accepts one instruction word per EXEC request.
//  - Steps it through operand/result cycles by driving register read/write enables, AIN, GIN, GOUT, FN and

---
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction-side and datapath-control signals of the ALU sequencer.
// EXEC is sampled only while BUSY is low, so BUSY is the not-ready indication.
interface alu_sequencer_if #(parameter int N = 10);
  logic         EXEC;
  logic [N-1:0] INSTR;
  logic [3:0]   R_OUT;
  logic [3:0]   R_IN;
  logic         IMM_OUT;
  logic [1:0]   OP_MODE;
  logic [3:0]   FN;
  logic         AIN;
  logic         GIN;
  logic         GOUT;
  logic         BUSY;
  logic         DONE;
  logic         ILLEGAL;
  logic [2:0]   state_dbg;

  modport master (
    output EXEC, INSTR,
    input  R_OUT, R_IN, IMM_OUT, OP_MODE, FN, AIN, GIN, GOUT, BUSY, DONE, ILLEGAL, state_dbg
  );

  modport slave (
    input  EXEC, INSTR,
    output R_OUT, R_IN, IMM_OUT, OP_MODE, FN, AIN, GIN, GOUT, BUSY, DONE, ILLEGAL, state_dbg
  );
endinterface

// File: rtl/alu_sequencer.sv
// Falling-edge control FSM that steps one instruction through the ALU and register file.
// All outputs are registered, decoded from the next state and next IR.
module alu_sequencer #(
  parameter int N = 10
) (
  input logic            CLKb,
  input logic            RST,
  alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] ir_q, ir_d;
  logic         flag_q, flag_d;

  logic [3:0] r_out_q, r_out_d;
  logic [3:0] r_in_q, r_in_d;
  logic       imm_out_q, imm_out_d;
  logic [1:0] op_mode_q, op_mode_d;
  logic [3:0] fn_q, fn_d;
  logic       ain_q, ain_d;
  logic       gin_q, gin_d;
  logic       gout_q, gout_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;

  logic [1:0] c_mode, n_mode, n_rx, n_ry;
  logic [3:0] c_fn, n_fn;
  logic       c_legal, n_legal;

  assign c_mode  = ir_q[9:8];
  assign c_fn    = ir_q[3:0];
  assign c_legal = (c_fn >= 4'd2) && (c_fn <= 4'd11);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.EXEC) begin
          ir_d    = bus.INSTR;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (c_mode == 2'b01) begin
          state_d = S_FIN;
        end else if (c_mode == 2'b00 && !c_legal) begin
          flag_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_T2;
        end
      end
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_FIN;
      S_FIN: begin
        flag_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoding the upcoming state lets the outputs be flops yet line up with the state.
  assign n_mode  = ir_d[9:8];
  assign n_rx    = ir_d[7:6];
  assign n_ry    = ir_d[5:4];
  assign n_fn    = ir_d[3:0];
  assign n_legal = (n_fn >= 4'd2) && (n_fn <= 4'd11);

  always_comb begin
    r_out_d   = 4'b0000;
    r_in_d    = 4'b0000;
    imm_out_d = 1'b0;
    ain_d     = 1'b0;
    gin_d     = 1'b0;
    gout_d    = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    op_mode_d = n_mode;
    fn_d      = (n_mode == 2'b00) ? n_fn : 4'b0000;
    case (state_d)
      S_T1: begin
        if (n_mode == 2'b01) begin
          r_out_d = 4'b0001 << n_ry;
          r_in_d  = 4'b0001 << n_rx;
        end else if (!(n_mode == 2'b00 && !n_legal)) begin
          r_out_d = 4'b0001 << n_rx;
          ain_d   = 1'b1;
        end
      end
      S_T2: begin
        if (n_mode == 2'b00) r_out_d = 4'b0001 << n_ry;
        else                 imm_out_d = 1'b1;
        gin_d = 1'b1;
      end
      S_T3: begin
        gout_d = 1'b1;
        r_in_d = 4'b0001 << n_rx;
      end
      S_FIN: begin
        done_d    = 1'b1;
        illegal_d = flag_d;
      end
      default: ;
    endcase
  end

  // Async reset clears R_IN at once, so an interrupted T3 never writes.
  always_ff @(negedge CLKb or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      flag_q    <= 1'b0;
      r_out_q   <= 4'b0000;
      r_in_q    <= 4'b0000;
      imm_out_q <= 1'b0;
      op_mode_q <= 2'b00;
      fn_q      <= 4'b0000;
      ain_q     <= 1'b0;
      gin_q     <= 1'b0;
      gout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      flag_q    <= flag_d;
      r_out_q   <= r_out_d;
      r_in_q    <= r_in_d;
      imm_out_q <= imm_out_d;
      op_mode_q <= op_mode_d;
      fn_q      <= fn_d;
      ain_q     <= ain_d;
      gin_q     <= gin_d;
      gout_q    <= gout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.R_OUT     = r_out_q;
  assign bus.R_IN      = r_in_q;
  assign bus.IMM_OUT   = imm_out_q;
  assign bus.OP_MODE   = op_mode_q;
  assign bus.FN        = fn_q;
  assign bus.AIN       = ain_q;
  assign bus.GIN       = gin_q;
  assign bus.GOUT      = gout_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ILLEGAL   = illegal_q;
  assign bus.state_dbg = state_q;

endmodule
